// File: rtl/vga_text_sequencer.sv
// -----------------------------------------------------------------------------
// vga_text_sequencer
//   Generates 640x480 VGA timing and turns an 80x30 character buffer plus an
//   8x16 font ROM into a per-pixel foreground/background select, with a
//   blinking underline cursor. Four-stage pipeline:
//     stage 0: cell address to the text buffer, timing/cursor sampled
//     stage 1: character code to the font ROM, colours captured
//     stage 2: pixel bit picked out of the glyph row (combinational)
//     stage 3: all pixel-side outputs registered together
//   Counter position to pixel outputs is exactly 3 clocks.
//
// Ports
//   clk, rst        pixel clock, asynchronous active-high reset
//   text_addr       text buffer address = row*80 + col (data back next cycle)
//   text_data       {char[15:8], fg[7:4], bg[3:0]}
//   font_addr       {char, glyph_row}  (data back next cycle)
//   font_data       glyph row bitmap, bit 7 = leftmost pixel
//   cursor_x/y/en   cursor cell and enable, sampled per cell at stage 0
//   hsync, vsync    active-low syncs
//   de              display enable
//   fb              1 = foreground colour, 0 = background colour
//   fg_color        foreground colour index
//   bg_color        background colour index
//   frame_start     one-cycle pulse on the pixel derived from h=0, v=0
// -----------------------------------------------------------------------------
module vga_text_sequencer #(
  parameter int H_ACTIVE     = 640,
  parameter int H_FP         = 16,
  parameter int H_SYNC       = 96,
  parameter int H_BP         = 48,
  parameter int V_ACTIVE     = 480,
  parameter int V_FP         = 10,
  parameter int V_SYNC       = 2,
  parameter int V_BP         = 33,
  parameter int BLINK_FRAMES = 32
) (
  input  logic        clk,
  input  logic        rst,
  output logic [11:0] text_addr,
  input  logic [15:0] text_data,
  output logic [11:0] font_addr,
  input  logic [7:0]  font_data,
  input  logic [6:0]  cursor_x,
  input  logic [4:0]  cursor_y,
  input  logic        cursor_en,
  output logic        hsync,
  output logic        vsync,
  output logic        de,
  output logic        fb,
  output logic [3:0]  fg_color,
  output logic [3:0]  bg_color,
  output logic        frame_start
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HS_BEG  = H_ACTIVE + H_FP;
  localparam int HS_END  = HS_BEG + H_SYNC;
  localparam int VS_BEG  = V_ACTIVE + V_FP;
  localparam int VS_END  = VS_BEG + V_SYNC;
  localparam int FC_W    = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  // Raster counters
  logic [9:0] r_h_cnt, r_v_cnt;
  // Stage 0 -> 1
  logic [11:0] r_text_addr;
  logic [2:0]  r_h_d1;
  logic [3:0]  r_v_d1;
  logic        r_de_d1, r_hs_d1, r_vs_d1, r_cur_d1, r_fs_d1;
  // Stage 1 -> 2
  logic [11:0] r_font_addr;
  logic [3:0]  r_fg_d2, r_bg_d2;
  logic [2:0]  r_h_d2;
  logic        r_de_d2, r_hs_d2, r_vs_d2, r_cur_d2, r_fs_d2;
  // Stage 3 outputs
  logic        r_hsync, r_vsync, r_de, r_fb, r_frame_start;
  logic [3:0]  r_fg, r_bg;
  // Cursor blink
  logic [FC_W-1:0] r_frame_cnt;
  logic            r_blink_on;

  logic        w_h_last, w_v_last, w_active, w_hs, w_vs, w_cur_hit, w_pix;
  logic [6:0]  w_col;
  logic [5:0]  w_row;
  logic [11:0] w_addr;

  always_comb begin
    w_h_last  = (r_h_cnt == 10'(H_TOTAL - 1));
    w_v_last  = (r_v_cnt == 10'(V_TOTAL - 1));
    w_active  = (r_h_cnt < 10'(H_ACTIVE)) && (r_v_cnt < 10'(V_ACTIVE));
    w_hs      = !((r_h_cnt >= 10'(HS_BEG)) && (r_h_cnt < 10'(HS_END)));
    w_vs      = !((r_v_cnt >= 10'(VS_BEG)) && (r_v_cnt < 10'(VS_END)));
    w_col     = r_h_cnt[9:3];
    w_row     = r_v_cnt[9:4];
    w_addr    = 12'(w_row) * 12'd80 + 12'(w_col);
    // Underline cursor: bottom two glyph rows (14, 15) of the cursor cell.
    w_cur_hit = cursor_en && r_blink_on && (w_col == cursor_x) &&
                (w_row == {1'b0, cursor_y}) && (r_v_cnt[3:1] == 3'b111);
  end

  // Stage 2: font_data belongs to the cell whose h low bits sit in r_h_d2.
  assign w_pix = font_data[3'd7 - r_h_d2];

  // NOTE: every register here resets asynchronously and is updated with
  // non-blocking assignments so all stages see the previous-cycle values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_h_cnt <= '0;
      r_v_cnt <= '0;
    end else if (w_h_last) begin
      r_h_cnt <= '0;
      r_v_cnt <= w_v_last ? 10'd0 : r_v_cnt + 10'd1;
    end else begin
      r_h_cnt <= r_h_cnt + 10'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_text_addr <= '0;
      r_h_d1 <= '0;  r_v_d1 <= '0;
      r_de_d1 <= 1'b0; r_hs_d1 <= 1'b1; r_vs_d1 <= 1'b1;
      r_cur_d1 <= 1'b0; r_fs_d1 <= 1'b0;
      r_font_addr <= '0;
      r_fg_d2 <= '0; r_bg_d2 <= '0; r_h_d2 <= '0;
      r_de_d2 <= 1'b0; r_hs_d2 <= 1'b1; r_vs_d2 <= 1'b1;
      r_cur_d2 <= 1'b0; r_fs_d2 <= 1'b0;
      r_hsync <= 1'b1; r_vsync <= 1'b1; r_de <= 1'b0; r_fb <= 1'b0;
      r_fg <= '0; r_bg <= '0; r_frame_start <= 1'b0;
    end else begin
      // Stage 0: the address only moves inside the visible area.
      if (w_active) r_text_addr <= w_addr;
      r_h_d1   <= r_h_cnt[2:0];
      r_v_d1   <= r_v_cnt[3:0];
      r_de_d1  <= w_active;
      r_hs_d1  <= w_hs;
      r_vs_d1  <= w_vs;
      r_cur_d1 <= w_cur_hit;
      r_fs_d1  <= (r_h_cnt == 10'd0) && (r_v_cnt == 10'd0);
      // Stage 1
      r_font_addr <= {text_data[15:8], r_v_d1};
      r_fg_d2  <= text_data[7:4];
      r_bg_d2  <= text_data[3:0];
      r_h_d2   <= r_h_d1;
      r_de_d2  <= r_de_d1;
      r_hs_d2  <= r_hs_d1;
      r_vs_d2  <= r_vs_d1;
      r_cur_d2 <= r_cur_d1;
      r_fs_d2  <= r_fs_d1;
      // Stage 3: colour fields are blanked outside the visible area.
      r_hsync <= r_hs_d2;
      r_vsync <= r_vs_d2;
      r_de    <= r_de_d2;
      r_fb    <= r_de_d2 & (w_pix | r_cur_d2);
      r_fg    <= r_de_d2 ? r_fg_d2 : 4'd0;
      r_bg    <= r_de_d2 ? r_bg_d2 : 4'd0;
      r_frame_start <= r_fs_d2;
    end
  end

  // Blink phase advances on the registered frame_start pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_frame_cnt <= '0;
      r_blink_on  <= 1'b1;
    end else if (r_frame_start) begin
      if (r_frame_cnt == FC_W'(BLINK_FRAMES - 1)) begin
        r_frame_cnt <= '0;
        r_blink_on  <= ~r_blink_on;
      end else begin
        r_frame_cnt <= r_frame_cnt + 1'b1;
      end
    end
  end

  assign text_addr   = r_text_addr;
  assign font_addr   = r_font_addr;
  assign hsync       = r_hsync;
  assign vsync       = r_vsync;
  assign de          = r_de;
  assign fb          = r_fb;
  assign fg_color    = r_fg;
  assign bg_color    = r_bg;
  assign frame_start = r_frame_start;

endmodule

// File: tb/tb_vga_text_sequencer.sv
// -----------------------------------------------------------------------------
// tb_vga_text_sequencer
//   Directed bench for vga_text_sequencer on a shrunken raster (80x54 clocks
//   per frame, 4-frame blink) so many frames fit in a short run. The text
//   buffer and font ROM are small combinational models driven off the DUT's
//   registered addresses. Outputs for raster pixel p are sampled #1 after
//   clock edge p+3, counted from reset release.
// -----------------------------------------------------------------------------
module tb_vga_text_sequencer;

  localparam int HA = 64, HF = 4, HS = 8, HB = 4;
  localparam int VA = 48, VF = 2, VS = 2, VB = 2;
  localparam int BF = 4;
  localparam int HT = HA + HF + HS + HB;  // 80
  localparam int VT = VA + VF + VS + VB;  // 54
  localparam int FR = HT * VT;            // 4320

  logic        clk = 1'b0;
  logic        rst;
  logic [11:0] text_addr, font_addr;
  logic [15:0] text_data;
  logic [7:0]  font_data;
  logic [6:0]  cursor_x;
  logic [4:0]  cursor_y;
  logic        cursor_en;
  logic        hsync, vsync, de, fb, frame_start;
  logic [3:0]  fg_color, bg_color;

  int n_total = 0;
  int n_bad   = 0;
  int edge_cnt;

  vga_text_sequencer #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
    .BLINK_FRAMES(BF)
  ) dut (
    .clk(clk), .rst(rst),
    .text_addr(text_addr), .text_data(text_data),
    .font_addr(font_addr), .font_data(font_data),
    .cursor_x(cursor_x), .cursor_y(cursor_y), .cursor_en(cursor_en),
    .hsync(hsync), .vsync(vsync), .de(de), .fb(fb),
    .fg_color(fg_color), .bg_color(bg_color), .frame_start(frame_start)
  );

  always #5 clk = ~clk;

  // Edges since reset release; edge k carries pixel k-3 to the outputs.
  always @(posedge clk or posedge rst)
    if (rst) edge_cnt <= 0;
    else     edge_cnt <= edge_cnt + 1;

  // Text buffer: cell 0 'A' E/1, cell 1 'B' 5/A, every other cell a blank
  // glyph code with fg=7, bg=2.
  function automatic logic [15:0] text_of(logic [11:0] a);
    if (a == 12'd0)      return 16'h41E1;
    else if (a == 12'd1) return 16'h425A;
    else                 return {a[7:0] ^ 8'h55, 8'h72};
  endfunction

  function automatic logic [7:0] font_of(logic [11:0] a);
    if (a[11:4] == 8'h41)      return (a[3:0] == 4'd0) ? 8'h81 : 8'h18;
    else if (a[11:4] == 8'h42) return 8'h3C;
    else                       return 8'h00;
  endfunction

  assign text_data = text_of(text_addr);
  assign font_data = font_of(font_addr);

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic wait_edge(input int k);
    int guard = 0;
    while (edge_cnt < k && guard < 100000) begin
      @(posedge clk);
      #1;
      guard++;
    end
    if (edge_cnt < k) check("wait_timeout", edge_cnt, k);
  endtask

  function automatic int px(input int f, input int v, input int h);
    return f * FR + v * HT + h;
  endfunction

  task automatic at_pixel(input int p);
    wait_edge(p + 3);
  endtask

  initial begin
    rst = 1'b1;
    cursor_x = 7'd3; cursor_y = 5'd2; cursor_en = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_hsync", hsync, 1'b1);
    check("rst_vsync", vsync, 1'b1);
    check("rst_de", de, 1'b0);
    check("rst_fb", fb, 1'b0);
    check("rst_colors", {fg_color, bg_color}, 8'h00);
    check("rst_fs", frame_start, 1'b0);
    check("rst_text_addr", text_addr, 12'd0);
    check("rst_font_addr", font_addr, 12'd0);

    @(negedge clk) rst = 1'b0;

    // First frame: pulse lands on the 3rd edge together with pixel 0.
    wait_edge(2);
    check("fs_early", frame_start, 1'b0);
    at_pixel(0);
    check("fs_first", frame_start, 1'b1);
    check("de_first", de, 1'b1);
    check("fb_px0", fb, 1'b1);
    check("fg_px0", fg_color, 4'hE);
    check("bg_px0", bg_color, 4'h1);
    at_pixel(1);
    check("fs_one_cycle", frame_start, 1'b0);
    check("fb_px1", fb, 1'b0);
    at_pixel(6);  check("fb_px6", fb, 1'b0);
    at_pixel(7);  check("fb_px7", fb, 1'b1);
    at_pixel(8);
    check("fb_px8", fb, 1'b0);
    check("fg_px8", fg_color, 4'h5);
    check("bg_px8", bg_color, 4'hA);
    at_pixel(10); check("fb_px10", fb, 1'b1);
    at_pixel(64);
    check("de_blank", de, 1'b0);
    check("fb_blank", fb, 1'b0);
    check("colors_blank", {fg_color, bg_color}, 8'h00);
    at_pixel(67); check("hs_before", hsync, 1'b1);
    at_pixel(68); check("hs_start", hsync, 1'b0);
    at_pixel(75); check("hs_end", hsync, 1'b0);
    at_pixel(76); check("hs_after", hsync, 1'b1);

    // Glyph row 1 of 'A' is 0x18.
    at_pixel(px(0, 1, 2)); check("fb_r1_px2", fb, 1'b0);
    at_pixel(px(0, 1, 3)); check("fb_r1_px3", fb, 1'b1);

    // Address stages: text_addr after edge p+1, font_addr after edge p+2.
    wait_edge(px(0, 16, 8) + 1); check("text_addr_81", text_addr, 12'd81);
    wait_edge(px(0, 16, 8) + 2); check("font_addr_81", font_addr, 12'h040);

    // Cursor cell (3,2): lines 46..47, pixels 24..31.
    at_pixel(px(0, 45, 24)); check("cur_line45", fb, 1'b0);
    at_pixel(px(0, 46, 23)); check("cur_px23", fb, 1'b0);
    at_pixel(px(0, 46, 24));
    check("cur_px24", fb, 1'b1);
    check("cur_fg", fg_color, 4'h7);
    at_pixel(px(0, 46, 31)); check("cur_px31", fb, 1'b1);
    at_pixel(px(0, 46, 32)); check("cur_px32", fb, 1'b0);
    at_pixel(px(0, 47, 28)); check("cur_line47", fb, 1'b1);

    wait_edge(px(0, 47, 63) + 1); check("text_addr_last", text_addr, 12'd167);
    wait_edge(px(0, 47, 70) + 1); check("text_addr_hold", text_addr, 12'd167);

    at_pixel(px(0, 49, 0));  check("vs_before", vsync, 1'b1);
    at_pixel(px(0, 50, 0));  check("vs_start", vsync, 1'b0);
    at_pixel(px(0, 51, 79)); check("vs_end", vsync, 1'b0);
    at_pixel(px(0, 52, 0));  check("vs_after", vsync, 1'b1);

    at_pixel(px(1, 0, 0)); check("fs_frame1", frame_start, 1'b1);
    at_pixel(px(1, 0, 1)); check("fs_frame1_end", frame_start, 1'b0);

    // Blink: off in frame 4, on again in frame 8.
    at_pixel(px(4, 46, 24)); check("blink_off", fb, 1'b0);
    at_pixel(px(8, 46, 24)); check("blink_on", fb, 1'b1);

    // Mid-frame reset inside the lit cursor cell.
    at_pixel(px(8, 47, 30));
    check("pre_rst_de", de, 1'b1);
    check("pre_rst_fb", fb, 1'b1);
    rst = 1'b1;
    #2;
    check("mid_rst_de", de, 1'b0);
    check("mid_rst_fb", fb, 1'b0);
    check("mid_rst_colors", {fg_color, bg_color}, 8'h00);
    check("mid_rst_syncs", {hsync, vsync}, 2'b11);
    check("mid_rst_addrs", {text_addr, font_addr}, 24'h0);
    repeat (2) @(posedge clk);
    @(negedge clk) rst = 1'b0;
    wait_edge(2); check("re_fs_early", frame_start, 1'b0);
    wait_edge(3); check("re_fs", frame_start, 1'b1);
    wait_edge(4); check("re_fs_end", frame_start, 1'b0);
    at_pixel(67); check("re_hs_before", hsync, 1'b1);
    at_pixel(68); check("re_hs_start", hsync, 1'b0);
    at_pixel(px(0, 46, 24)); check("re_blink_on", fb, 1'b1);
    at_pixel(px(1, 0, 0)); check("re_fs_frame1", frame_start, 1'b1);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
